// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a RUN/HALTED FSM.
// Redirect has priority over halt, and halt has priority over stall. HALTED is left only by reset.
module if_fetch_stage #(
  parameter logic [8:0]  RESET_PC  = 9'h000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [8:0]  redirect_pc,
  input  logic        halt_req,
  output logic [8:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [8:0]  if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state, state_nxt;
  logic [8:0]  pc, pc_nxt;
  logic [8:0]  if_id_pc_nxt;
  logic [31:0] if_id_instr_nxt;
  logic        if_id_valid_nxt;
  logic [15:0] fetch_count_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_pc    <= 9'h000;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_id_pc    <= if_id_pc_nxt;
      if_id_instr <= if_id_instr_nxt;
      if_id_valid <= if_id_valid_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    if_id_pc_nxt    = if_id_pc;
    if_id_instr_nxt = if_id_instr;
    if_id_valid_nxt = if_id_valid;
    fetch_count_nxt = fetch_count;
    if (state == RUN) begin
      if (redirect_valid) begin
        // Word-align the target; the slot being fetched becomes a bubble.
        pc_nxt          = {redirect_pc[8:2], 2'b00};
        if_id_pc_nxt    = pc;
        if_id_instr_nxt = NOP_INSTR;
        if_id_valid_nxt = 1'b0;
      end else if (halt_req) begin
        state_nxt       = HALTED;
        if_id_pc_nxt    = pc;
        if_id_instr_nxt = NOP_INSTR;
        if_id_valid_nxt = 1'b0;
      end else if (!stall) begin
        pc_nxt          = pc + 9'd4;
        if_id_pc_nxt    = pc;
        if_id_instr_nxt = imem_rdata;
        if_id_valid_nxt = 1'b1;
        if (fetch_count != 16'hFFFF)
          fetch_count_nxt = fetch_count + 16'd1;
      end
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == HALTED);

endmodule
